kulisch_stream_accumulator: RTL

//  Streaming, multi-channel Kulisch accumulator. Accepts (exponent, signed fixed, inf) beats with valid/ready.

---
 rtl/kulisch_stream_pkg.sv | 24 ++
 rtl/kulisch_fixed_shift.sv | 40 ++++
 rtl/kulisch_stream_accumulator.sv | 139 +++++++++++++
 3 files changed

// File: rtl/kulisch_stream_pkg.sv
// Shared sizing, accumulator state type and helpers for the Kulisch stream accumulator.
// acc_t is sized from the package defaults, so resizing the accumulator means editing these values.
package kulisch_stream_pkg;

  function automatic int acc_bits(input int nonFrac, input int frac);
    return nonFrac + frac + 1;
  endfunction

  localparam int ACC_NON_FRAC_DEF = 8;
  localparam int ACC_FRAC_DEF     = 8;
  localparam int ACC_DATA_BITS    = acc_bits(ACC_NON_FRAC_DEF, ACC_FRAC_DEF);

  typedef struct packed {
    logic                     is_inf;
    logic                     is_overflow;
    logic                     overflow_sign;
    logic [ACC_DATA_BITS-1:0] data;
  } acc_t;

  function automatic acc_t zero();
    return '0;
  endfunction

endpackage

// File: rtl/kulisch_fixed_shift.sv
// Combinational fixed-to-Kulisch convert: places a signed fixed operand at an accumulator bit
// position and flags the case where the shifted value cannot be represented.
module kulisch_fixed_shift #(
  parameter int FRAC     = 4,
  parameter int ACC_BITS = 17,
  parameter int EXP      = 6
) (
  input  logic [2+FRAC:0]    fixed,
  input  logic [EXP-1:0]     shift,
  output logic [ACC_BITS-1:0] term,
  output logic               cOvf,
  output logic               cSign
);

  localparam int FIX_W = 3 + FRAC;
  localparam int WIDE  = ACC_BITS + FIX_W;
  localparam logic [EXP-1:0] SHIFT_LIMIT = EXP'(ACC_BITS);

  logic [WIDE-1:0]         wideVal;
  logic [WIDE-1:0]         shifted;
  logic [WIDE-ACC_BITS:0]  topBits;

  // For shift < ACC_BITS nothing is lost in the wide word, so the value fits exactly
  // when every bit from the accumulator sign position upward agrees.
  always_comb begin
    wideVal = {{ACC_BITS{fixed[FIX_W-1]}}, fixed};
    shifted = wideVal << shift;
    topBits = shifted[WIDE-1:ACC_BITS-1];
    cSign   = fixed[FIX_W-1];
    if (fixed == '0) begin
      cOvf = 1'b0;
    end else if (shift >= SHIFT_LIMIT) begin
      cOvf = 1'b1;
    end else begin
      cOvf = !((topBits == '0) || (&topBits));
    end
    term = cOvf ? '0 : shifted[ACC_BITS-1:0];
  end

endmodule

// File: rtl/kulisch_stream_accumulator.sv
// Multi-channel streaming Kulisch accumulator: convert stage, accumulate stage with per-channel
// read-modify-write, and a registered flush port that back-pressures the whole pipe.
module kulisch_stream_accumulator
  import kulisch_stream_pkg::*;
#(
  parameter int FRAC         = 4,
  parameter int ACC_NON_FRAC = ACC_NON_FRAC_DEF,
  parameter int ACC_FRAC     = ACC_FRAC_DEF,
  parameter int NUM_CH       = 4,
  localparam int ACC_BITS    = acc_bits(ACC_NON_FRAC, ACC_FRAC),
  localparam int EXP         = $clog2(ACC_BITS) + 1,
  localparam int CHW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CHW-1:0]      in_chan,
  input  logic [EXP-1:0]      in_exp,
  input  logic [2+FRAC:0]     in_fixed,
  input  logic                in_inf,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CHW-1:0]      out_chan,
  output logic [ACC_BITS-1:0] out_acc,
  output logic                out_is_inf,
  output logic                out_is_overflow,
  output logic                out_overflow_sign
);

  logic advance;
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  logic [ACC_BITS-1:0] cTerm;
  logic                cOvf;
  logic                cSign;

  kulisch_fixed_shift #(
    .FRAC     (FRAC),
    .ACC_BITS (ACC_BITS),
    .EXP      (EXP)
  ) uShift (
    .fixed (in_fixed),
    .shift (in_exp),
    .term  (cTerm),
    .cOvf  (cOvf),
    .cSign (cSign)
  );

  logic                s1Valid, s1Ovf, s1Sign, s1Inf, s1Last;
  logic [CHW-1:0]      s1Chan;
  logic [ACC_BITS-1:0] s1Term;
  logic                s2Valid, s2Ovf, s2Sign, s2Inf, s2Last;
  logic [CHW-1:0]      s2Chan;
  logic [ACC_BITS-1:0] s2Term;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1Valid <= 1'b0; s1Ovf <= 1'b0; s1Sign <= 1'b0; s1Inf <= 1'b0; s1Last <= 1'b0;
      s1Chan  <= '0;   s1Term <= '0;
      s2Valid <= 1'b0; s2Ovf <= 1'b0; s2Sign <= 1'b0; s2Inf <= 1'b0; s2Last <= 1'b0;
      s2Chan  <= '0;   s2Term <= '0;
    end else if (advance) begin
      s1Valid <= in_valid;
      s1Chan  <= in_chan;
      s1Term  <= cTerm;
      s1Ovf   <= cOvf;
      s1Sign  <= cSign;
      s1Inf   <= in_inf;
      s1Last  <= in_last;
      s2Valid <= s1Valid;
      s2Chan  <= s1Chan;
      s2Term  <= s1Term;
      s2Ovf   <= s1Ovf;
      s2Sign  <= s1Sign;
      s2Inf   <= s1Inf;
      s2Last  <= s1Last;
    end
  end

  acc_t                accReg [NUM_CH];
  acc_t                accCur;
  acc_t                accNew;
  logic [ACC_BITS:0]   sumWide;
  logic                addOvf;
  logic                anyOvf;

  // The accumulator is only read and written here, so back-to-back beats on one channel
  // always see the previous beat's result without forwarding.
  always_comb begin
    accCur  = accReg[s2Chan];
    sumWide = {accCur.data[ACC_BITS-1], accCur.data} + {s2Term[ACC_BITS-1], s2Term};
    addOvf  = sumWide[ACC_BITS] != sumWide[ACC_BITS-1];
    anyOvf  = addOvf || s2Ovf;
    accNew.data          = sumWide[ACC_BITS-1:0];
    accNew.is_inf        = accCur.is_inf | s2Inf;
    accNew.is_overflow   = accCur.is_overflow | anyOvf;
    accNew.overflow_sign = accCur.overflow_sign;
    if (!accCur.is_overflow && anyOvf) begin
      accNew.overflow_sign = s2Ovf ? s2Sign : s2Term[ACC_BITS-1];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        accReg[i] <= zero();
      end
    end else if (advance && s2Valid) begin
      accReg[s2Chan] <= s2Last ? zero() : accNew;
    end
  end

  // A new flush may replace a result in the same cycle it is consumed.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid         <= 1'b0;
      out_chan          <= '0;
      out_acc           <= '0;
      out_is_inf        <= 1'b0;
      out_is_overflow   <= 1'b0;
      out_overflow_sign <= 1'b0;
    end else if (advance) begin
      if (s2Valid && s2Last) begin
        out_valid         <= 1'b1;
        out_chan          <= s2Chan;
        out_acc           <= accNew.data;
        out_is_inf        <= accNew.is_inf;
        out_is_overflow   <= accNew.is_overflow;
        out_overflow_sign <= accNew.overflow_sign;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
